decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Registered RV32I instruction decoder for the pipelined core; sits between fetch (IF) and execute (EX).
- Accepts one instruction per cycle over a valid/ready handshake and generates main control and the immediate.
- Output register is the ID/EX boundary.
- Adds three things the single-cycle controller lacks: illegal-instruction detection, a configurable load-use interlock, and flush.

Parameters:
- XLEN, 32, width of pc and imm (32 or 64; imm sign-extended to XLEN).
- LOAD_USE_STALL, 1, bubbles inserted on a load-use hazard (0..3). 0 disables the interlock.
- ALUOP_W, 4, ALU operation code width.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  IF holds an instruction
- in_ready  out  1  decoder accepts this cycle (combinational)
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction address
- flush  in  1  kill held and incoming instruction (branch redirect)
- out_valid  out  1  ID/EX register valid
- out_ready  in  1  EX accepts
- alu_op  out  ALUOP_W  ALU code (package constants)
- itype  out  3  0 R, 1 I, 2 S, 3 B, 4 U, 5 J
- reg_write, mem_read, branch, jal, jalr, lui, auipc  out  1 each  control
- mem_write  out  4  byte-lane write mask
- ext_b, ext_h, sgn, uns  out  1 each  load/store width and signedness
- rd, rs1, rs2  out  5 each  register indices
- imm  out  XLEN  sign-extended immediate (I/S/B/U/J forms)
- pc_out  out  XLEN  registered in_pc
- illegal  out  1  unrecognised encoding

Behaviour:
- Reset: all outputs are 0, and the stall counter is 0.
- Latency is 1 cycle: an instruction accepted in cycle t appears on the outputs in cycle t+1.

Handshake:
- accept = in_valid & in_ready. fire = out_valid & out_ready.
- in_ready = ~rst & ~flush & (stall_cnt==0) & (~out_valid | out_ready) & ~hazard.
- On accept: load all fields and set out_valid.
- On fire without accept: clear out_valid.
- Outputs are held stable while out_valid & ~out_ready.

Decode:
- R ops: add 1, sub 2, and 3, or 4, xor 5, slt 7 (sgn), sll 8 (uns), srl 9 (uns), sra 13 (sgn), sltu 14 (uns).
- I-ALU ops: same codes. srli vs srai is selected by instr[30]; slli/srli/srai require funct7 = 0000000 or 0100000 as applicable.
- Loads lb/lh/lw/lbu/lhu: alu 1, mem_read 1. ext_b/ext_h per width; sgn for lb/lh, uns for lbu/lhu.
- Stores: alu 1, reg_write 0. mem_write is 0001 for sb, 0011 for sh, 1111 for sw.
- Branches: reg_write 0, branch 1. beq 10, bne 11, blt 7, bge 12, bltu 14, bgeu 15.
- Jumps: jal sets jal; jalr (funct3 000) sets jalr with alu 1. Both write rd.
- U-type: lui sets lui, auipc sets auipc; alu 1, imm = instr[31:12]<<12.
- Register fields: rd/rs1/rs2 are always the raw instruction fields.

Illegal instructions:
- Any other opcode, funct3 or funct7 sets illegal=1.
- All side-effect controls are then forced to 0: reg_write, mem_read, mem_write, branch, jal, jalr.

Load-use interlock (only when LOAD_USE_STALL>0):
- hazard = fire & q.mem_read & q.rd!=0 & in_valid & ((uses_rs1 & in.rs1==q.rd) | (uses_rs2 & in.rs2==q.rd)).
- uses_rs1 is true for types R, I, S, B. uses_rs2 is true for R, S, B.
- When hazard is true: the instruction is not accepted, stall_cnt <= LOAD_USE_STALL-1, and out_valid falls next cycle.
- stall_cnt decrements each cycle while nonzero.
- Net effect: exactly LOAD_USE_STALL bubble cycles.

Flush:
- Next cycle out_valid=0 and stall_cnt=0.
- The instruction presented in the flush cycle is not accepted.
- Flush has priority over accept and hazard.

Reset mid-stall clears the counter and out_valid.

Decomposition:
- decode_pkg holds: opcode constants, ALUOP_* codes, TYPE_* codes, and a ctrl_t struct bundling all control outputs.
- Sub-module imm_gen (combinational; instr -> XLEN immediate by type) is instantiated once.
- The control decode and the ID/EX register stay in decode_stage.

Test Plan:
- Reset, then add x3,x1,x2 = 0x002081B3 with out_ready=1 -> next cycle out_valid=1, alu_op=1, itype=0, rd=3, rs1=1, rs2=2, reg_write=1, illegal=0.
- sw x2,8(x1) = 0x0020A423 -> mem_write=4'b1111, reg_write=0, imm=8, itype=2. Then srai x1,x1,3 = 0x4030D093 -> alu_op=13, sgn=1, imm=3.
- lw x5,0(x1) = 0x0000A283, then add x6,x5,x0 = 0x00028333 back-to-back with LOAD_USE_STALL=1 -> lw valid at t+1, out_valid=0 at t+2, add valid at t+3. With LOAD_USE_STALL=0 -> add valid at t+2.
- lui x1,0x12345 = 0x123450B7 -> lui=1, itype=4, imm=0x12345000. Then 0xFFFFFFFF -> illegal=1, reg_write=0, mem_write=0.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0. Assert flush in cycle 2 -> out_valid=0 next cycle, presented instruction not accepted.
- Assert rst during a LOAD_USE_STALL=3 stall -> next cycle all outputs 0, in_ready=1 one cycle after rst deasserts.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared encodings for the ID stage: RV32I opcodes, ALU operation codes,
// immediate-format types and the bundled control word carried into ID/EX.
package decode_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [3:0] ALU_NONE = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_BEQ  = 4'd10;
    localparam logic [3:0] ALU_BNE  = 4'd11;
    localparam logic [3:0] ALU_BGE  = 4'd12;
    localparam logic [3:0] ALU_SRA  = 4'd13;
    localparam logic [3:0] ALU_SLTU = 4'd14;
    localparam logic [3:0] ALU_BGEU = 4'd15;

    typedef enum logic [2:0] {
        TYPE_R = 3'd0,
        TYPE_I = 3'd1,
        TYPE_S = 3'd2,
        TYPE_B = 3'd3,
        TYPE_U = 3'd4,
        TYPE_J = 3'd5
    } itype_e;

    typedef struct packed {
        logic [3:0] alu_op;
        itype_e     itype;
        logic       reg_write;
        logic       mem_read;
        logic [3:0] mem_write;
        logic       branch;
        logic       jal;
        logic       jalr;
        logic       lui;
        logic       auipc;
        logic       ext_b;
        logic       ext_h;
        logic       sgn;
        logic       uns;
        logic       illegal;
    } ctrl_t;

    // {sgn, uns} for the register/immediate ALU ops that care about signedness
    function automatic logic [1:0] alu_signedness(input logic [3:0] op);
        return {(op == ALU_SLT) || (op == ALU_SRA),
                (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SLTU)};
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: extracts the I/S/B/U/J immediate from an instruction
// word and sign-extends it to XLEN.
module imm_gen
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  itype_e          itype,
    output logic [XLEN-1:0] imm
);

    logic signed [31:0] raw;
    logic               is_shift_imm;

    // slli/srli/srai carry only a shift amount; the funct7 bits are not part of the immediate
    assign is_shift_imm = (instr[6:0] == OP_IMM) && (instr[13:12] == 2'b01);

    always_comb begin
        raw = '0;
        case (itype)
            TYPE_I:  raw = is_shift_imm ? {27'd0, instr[24:20]}
                                        : {{20{instr[31]}}, instr[31:20]};
            TYPE_S:  raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            TYPE_B:  raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            TYPE_U:  raw = {instr[31:12], 12'd0};
            TYPE_J:  raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: raw = '0;
        endcase
    end

    assign imm = XLEN'(raw);

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes one instruction per cycle into the ID/EX register,
// with illegal-encoding detection, a configurable load-use interlock and flush.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int LOAD_USE_STALL = 1,
    parameter int ALUOP_W        = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_instr,
    input  logic [XLEN-1:0]    in_pc,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [2:0]         itype,
    output logic               reg_write,
    output logic               mem_read,
    output logic               branch,
    output logic               jal,
    output logic               jalr,
    output logic               lui,
    output logic               auipc,
    output logic [3:0]         mem_write,
    output logic               ext_b,
    output logic               ext_h,
    output logic               sgn,
    output logic               uns,
    output logic [4:0]         rd,
    output logic [4:0]         rs1,
    output logic [4:0]         rs2,
    output logic [XLEN-1:0]    imm,
    output logic [XLEN-1:0]    pc_out,
    output logic               illegal
);

    localparam bit         INTERLOCK    = LOAD_USE_STALL > 0;
    localparam logic [1:0] STALL_RELOAD = INTERLOCK ? 2'(LOAD_USE_STALL - 1) : 2'd0;

    ctrl_t           dec;
    ctrl_t           q;
    logic [XLEN-1:0] dec_imm;
    logic [1:0]      stall_cnt;
    logic            fire;
    logic            accept;
    logic            hazard;
    logic            uses_rs1;
    logic            uses_rs2;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    always_comb begin
        dec       = '0;
        dec.itype = TYPE_R;
        case (opcode)
            OP_REG: begin
                dec.reg_write = 1'b1;
                case ({funct7, funct3})
                    {7'b0000000, 3'b000}: dec.alu_op = ALU_ADD;
                    {7'b0100000, 3'b000}: dec.alu_op = ALU_SUB;
                    {7'b0000000, 3'b001}: dec.alu_op = ALU_SLL;
                    {7'b0000000, 3'b010}: dec.alu_op = ALU_SLT;
                    {7'b0000000, 3'b011}: dec.alu_op = ALU_SLTU;
                    {7'b0000000, 3'b100}: dec.alu_op = ALU_XOR;
                    {7'b0000000, 3'b101}: dec.alu_op = ALU_SRL;
                    {7'b0100000, 3'b101}: dec.alu_op = ALU_SRA;
                    {7'b0000000, 3'b110}: dec.alu_op = ALU_OR;
                    {7'b0000000, 3'b111}: dec.alu_op = ALU_AND;
                    default:              dec.illegal = 1'b1;
                endcase
            end
            OP_IMM: begin
                dec.itype     = TYPE_I;
                dec.reg_write = 1'b1;
                case (funct3)
                    3'b000:  dec.alu_op = ALU_ADD;
                    3'b010:  dec.alu_op = ALU_SLT;
                    3'b011:  dec.alu_op = ALU_SLTU;
                    3'b100:  dec.alu_op = ALU_XOR;
                    3'b110:  dec.alu_op = ALU_OR;
                    3'b111:  dec.alu_op = ALU_AND;
                    3'b001:  if (funct7 == 7'b0000000) dec.alu_op = ALU_SLL;
                             else                      dec.illegal = 1'b1;
                    default: if (funct7 == 7'b0000000)      dec.alu_op = ALU_SRL;
                             else if (funct7 == 7'b0100000) dec.alu_op = ALU_SRA;
                             else                           dec.illegal = 1'b1;
                endcase
            end
            OP_LOAD: begin
                dec.itype     = TYPE_I;
                dec.alu_op    = ALU_ADD;
                dec.reg_write = 1'b1;
                dec.mem_read  = 1'b1;
                case (funct3)
                    3'b000:  {dec.ext_b, dec.sgn} = 2'b11;
                    3'b001:  {dec.ext_h, dec.sgn} = 2'b11;
                    3'b010:  dec.ext_b = 1'b0;
                    3'b100:  {dec.ext_b, dec.uns} = 2'b11;
                    3'b101:  {dec.ext_h, dec.uns} = 2'b11;
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_STORE: begin
                dec.itype  = TYPE_S;
                dec.alu_op = ALU_ADD;
                case (funct3)
                    3'b000:  {dec.mem_write, dec.ext_b} = {4'b0001, 1'b1};
                    3'b001:  {dec.mem_write, dec.ext_h} = {4'b0011, 1'b1};
                    3'b010:  dec.mem_write = 4'b1111;
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_BRANCH: begin
                dec.itype  = TYPE_B;
                dec.branch = 1'b1;
                case (funct3)
                    3'b000:  dec.alu_op = ALU_BEQ;
                    3'b001:  dec.alu_op = ALU_BNE;
                    3'b100:  dec.alu_op = ALU_SLT;
                    3'b101:  dec.alu_op = ALU_BGE;
                    3'b110:  dec.alu_op = ALU_SLTU;
                    3'b111:  dec.alu_op = ALU_BGEU;
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_JAL: begin
                dec.itype     = TYPE_J;
                dec.jal       = 1'b1;
                dec.reg_write = 1'b1;
            end
            OP_JALR: begin
                dec.itype     = TYPE_I;
                dec.alu_op    = ALU_ADD;
                dec.jalr      = 1'b1;
                dec.reg_write = 1'b1;
                dec.illegal   = (funct3 != 3'b000);
            end
            OP_LUI: begin
                dec.itype     = TYPE_U;
                dec.alu_op    = ALU_ADD;
                dec.lui       = 1'b1;
                dec.reg_write = 1'b1;
            end
            OP_AUIPC: begin
                dec.itype     = TYPE_U;
                dec.alu_op    = ALU_ADD;
                dec.auipc     = 1'b1;
                dec.reg_write = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase

        if ((opcode == OP_REG) || (opcode == OP_IMM))
            {dec.sgn, dec.uns} = alu_signedness(dec.alu_op);

        // an unrecognised encoding must never reach EX with anything that changes state
        if (dec.illegal) begin
            dec.reg_write = 1'b0;
            dec.mem_read  = 1'b0;
            dec.mem_write = 4'b0000;
            dec.branch    = 1'b0;
            dec.jal       = 1'b0;
            dec.jalr      = 1'b0;
        end
    end

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (in_instr),
        .itype (dec.itype),
        .imm   (dec_imm)
    );

    assign uses_rs1 = dec.itype inside {TYPE_R, TYPE_I, TYPE_S, TYPE_B};
    assign uses_rs2 = dec.itype inside {TYPE_R, TYPE_S, TYPE_B};

    // the load leaving ID/EX this cycle cannot forward to its direct consumer
    assign fire   = out_valid & out_ready;
    assign hazard = INTERLOCK && fire && q.mem_read && (rd != 5'd0) && in_valid &&
                    ((uses_rs1 && (in_instr[19:15] == rd)) || (uses_rs2 && (in_instr[24:20] == rd)));

    assign in_ready = ~rst & ~flush & (stall_cnt == 2'd0) & (~out_valid | out_ready) & ~hazard;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            q         <= '0;
            out_valid <= 1'b0;
            stall_cnt <= 2'd0;
            rd        <= '0;
            rs1       <= '0;
            rs2       <= '0;
            imm       <= '0;
            pc_out    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            stall_cnt <= 2'd0;
        end else begin
            if (accept) begin
                q         <= dec;
                out_valid <= 1'b1;
                rd        <= in_instr[11:7];
                rs1       <= in_instr[19:15];
                rs2       <= in_instr[24:20];
                imm       <= dec_imm;
                pc_out    <= in_pc;
            end else if (fire) begin
                out_valid <= 1'b0;
            end

            if (hazard)
                stall_cnt <= STALL_RELOAD;
            else if (stall_cnt != 2'd0)
                stall_cnt <= stall_cnt - 2'd1;
        end
    end

    assign alu_op    = ALUOP_W'(q.alu_op);
    assign itype     = q.itype;
    assign reg_write = q.reg_write;
    assign mem_read  = q.mem_read;
    assign mem_write = q.mem_write;
    assign branch    = q.branch;
    assign jal       = q.jal;
    assign jalr      = q.jalr;
    assign lui       = q.lui;
    assign auipc     = q.auipc;
    assign ext_b     = q.ext_b;
    assign ext_h     = q.ext_h;
    assign sgn       = q.sgn;
    assign uns       = q.uns;
    assign illegal   = q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: a scoreboard-checked instruction stream on a
// LOAD_USE_STALL=1 instance plus directed interlock/reset checks on 0 and 3.
module tb_decode_stage;

    typedef struct packed {
        logic [3:0]  alu_op;
        logic [2:0]  itype;
        logic        reg_write;
        logic        mem_read;
        logic [3:0]  mem_write;
        logic        branch;
        logic        jal;
        logic        jalr;
        logic        lui;
        logic        auipc;
        logic        ext_b;
        logic        ext_h;
        logic        sgn;
        logic        uns;
        logic        illegal;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] pc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        ordy;
    logic [31:0] instr;
    logic [31:0] pc;

    logic        ivld [3];
    logic        irdy [3];
    logic        ovld [3];
    logic [3:0]  alu_op [3];
    logic [2:0]  itype [3];
    logic        reg_write [3];
    logic        mem_read [3];
    logic        branch [3];
    logic        jal [3];
    logic        jalr [3];
    logic        lui [3];
    logic        auipc [3];
    logic [3:0]  mem_write [3];
    logic        ext_b [3];
    logic        ext_h [3];
    logic        sgn [3];
    logic        uns [3];
    logic [4:0]  rd [3];
    logic [4:0]  rs1 [3];
    logic [4:0]  rs2 [3];
    logic [31:0] imm [3];
    logic [31:0] pc_out [3];
    logic        illegal [3];

    exp_t  sb[$];
    bit    sb_part[$];
    string sb_tag[$];
    int    total = 0;
    int    bad   = 0;

    // instance 0: LOAD_USE_STALL=1, instance 1: 0, instance 2: 3
    for (genvar g = 0; g < 3; g++) begin : g_dut
        decode_stage #(
            .XLEN(32),
            .LOAD_USE_STALL(g == 0 ? 1 : (g == 1 ? 0 : 3)),
            .ALUOP_W(4)
        ) dut (
            .clk(clk), .rst(rst), .in_valid(ivld[g]), .in_ready(irdy[g]),
            .in_instr(instr), .in_pc(pc), .flush(flush),
            .out_valid(ovld[g]), .out_ready(ordy),
            .alu_op(alu_op[g]), .itype(itype[g]),
            .reg_write(reg_write[g]), .mem_read(mem_read[g]), .branch(branch[g]),
            .jal(jal[g]), .jalr(jalr[g]), .lui(lui[g]), .auipc(auipc[g]),
            .mem_write(mem_write[g]), .ext_b(ext_b[g]), .ext_h(ext_h[g]),
            .sgn(sgn[g]), .uns(uns[g]), .rd(rd[g]), .rs1(rs1[g]), .rs2(rs2[g]),
            .imm(imm[g]), .pc_out(pc_out[g]), .illegal(illegal[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s: got %h want %h", tag, obs, expv);
        end
    endtask

    function automatic exp_t obs0();
        exp_t o;
        o.alu_op = alu_op[0];       o.itype = itype[0];
        o.reg_write = reg_write[0]; o.mem_read = mem_read[0];
        o.mem_write = mem_write[0]; o.branch = branch[0];
        o.jal = jal[0];             o.jalr = jalr[0];
        o.lui = lui[0];             o.auipc = auipc[0];
        o.ext_b = ext_b[0];         o.ext_h = ext_h[0];
        o.sgn = sgn[0];             o.uns = uns[0];
        o.illegal = illegal[0];
        o.rd = rd[0];               o.rs1 = rs1[0];       o.rs2 = rs2[0];
        o.imm = imm[0];             o.pc = pc_out[0];
        return o;
    endfunction

    // register indices are always the raw instruction fields
    function automatic exp_t base(input logic [31:0] ins, input logic [31:0] p);
        exp_t e = '0;
        e.rd  = ins[11:7];
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        e.pc  = p;
        return e;
    endfunction

    task automatic checkOutput();
        exp_t  e;
        exp_t  o;
        bit    part;
        string tag;
        if (ovld[0] && ordy) begin
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("[TB] FAIL unexpected_out: got valid output rd=%0d want none pending", rd[0]);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front(); part = sb_part.pop_front(); tag = sb_tag.pop_front();
                o = obs0();
                if (part)
                    check(tag, {o.reg_write, o.mem_read, o.mem_write, o.branch, o.jal, o.jalr,
                                o.illegal, o.rd, o.rs1, o.rs2, o.pc},
                               {e.reg_write, e.mem_read, e.mem_write, e.branch, e.jal, e.jalr,
                                e.illegal, e.rd, e.rs1, e.rs2, e.pc});
                else
                    check(tag, o, e);
            end
        end
    endtask

    task automatic midCycle();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic endCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        midCycle();
        endCycle();
    endtask

    task automatic applyStimulus(input string tag, input logic [31:0] ins, input logic [31:0] p,
                                 input exp_t e, input bit part);
        bit acc = 1'b0;
        ivld[0] = 1'b1;
        instr   = ins;
        pc      = p;
        sb.push_back(e); sb_part.push_back(part); sb_tag.push_back(tag);
        for (int i = 0; i < 8 && !acc; i++) begin
            midCycle();
            acc = irdy[0];
            endCycle();
        end
        total++;
        assert (acc) else begin
            bad++;
            $error("[TB] FAIL %s_accept: got in_ready low for 8 cycles want accepted", tag);
        end
    endtask

    initial begin
        exp_t e;
        exp_t held;

        rst = 1'b1; flush = 1'b0; ordy = 1'b1; instr = '0; pc = '0;
        for (int i = 0; i < 3; i++) ivld[i] = 1'b0;
        endCycle();
        midCycle();
        check("rst_outputs", obs0(), '0);
        check("rst_valid", ovld[0], 1'b0);
        check("rst_in_ready", irdy[0], 1'b0);
        endCycle();
        rst = 1'b0;
        midCycle();
        check("ready_after_rst", irdy[0], 1'b1);
        endCycle();

        $display("[TB] instruction stream on LOAD_USE_STALL=1 instance");
        e = base(32'h002081B3, 32'h100); e.alu_op = 4'd1; e.reg_write = 1'b1;
        applyStimulus("add", 32'h002081B3, 32'h100, e, 1'b0);

        e = base(32'h0020A423, 32'h104); e.alu_op = 4'd1; e.itype = 3'd2;
        e.mem_write = 4'b1111; e.imm = 32'd8;
        applyStimulus("sw", 32'h0020A423, 32'h104, e, 1'b0);

        e = base(32'h4030D093, 32'h108); e.alu_op = 4'd13; e.itype = 3'd1;
        e.reg_write = 1'b1; e.sgn = 1'b1; e.imm = 32'd3;
        applyStimulus("srai", 32'h4030D093, 32'h108, e, 1'b0);

        e = base(32'h00209863, 32'h10C); e.alu_op = 4'd11; e.itype = 3'd3;
        e.branch = 1'b1; e.imm = 32'd16;
        applyStimulus("bne", 32'h00209863, 32'h10C, e, 1'b0);

        e = base(32'h0000A283, 32'h110); e.alu_op = 4'd1; e.itype = 3'd1;
        e.reg_write = 1'b1; e.mem_read = 1'b1;
        applyStimulus("lw", 32'h0000A283, 32'h110, e, 1'b0);

        // dependent add right behind the load: one bubble expected
        instr = 32'h00028333; pc = 32'h114;
        e = base(32'h00028333, 32'h114); e.alu_op = 4'd1; e.reg_write = 1'b1;
        sb.push_back(e); sb_part.push_back(1'b0); sb_tag.push_back("add_dep");
        midCycle();
        check("lw_valid_t1", ovld[0], 1'b1);
        check("hazard_ready", irdy[0], 1'b0);
        endCycle();
        midCycle();
        check("bubble_t2", ovld[0], 1'b0);
        check("ready_t2", irdy[0], 1'b1);
        endCycle();
        ivld[0] = 1'b0;
        midCycle();
        check("add_valid_t3", ovld[0], 1'b1);
        endCycle();

        e = base(32'h123450B7, 32'h118); e.alu_op = 4'd1; e.itype = 3'd4;
        e.lui = 1'b1; e.reg_write = 1'b1; e.imm = 32'h12345000;
        applyStimulus("lui", 32'h123450B7, 32'h118, e, 1'b0);

        e = base(32'hFFFFFFFF, 32'h11C); e.illegal = 1'b1;
        applyStimulus("illegal", 32'hFFFFFFFF, 32'h11C, e, 1'b1);
        ivld[0] = 1'b0;
        tick();
        tick();
        check("sb_drained", 128'(sb.size()), 128'd0);

        $display("[TB] back-pressure hold and flush");
        held = base(32'h0041F3B3, 32'h200); held.alu_op = 4'd3; held.reg_write = 1'b1;
        applyStimulus("and", 32'h0041F3B3, 32'h200, held, 1'b0);
        ordy = 1'b0; instr = 32'h002081B3; pc = 32'h204;
        midCycle();
        check("hold_c1", obs0(), held);
        check("hold_c1_ready", irdy[0], 1'b0);
        endCycle();
        flush = 1'b1;
        midCycle();
        check("hold_c2", obs0(), held);
        check("flush_ready", irdy[0], 1'b0);
        endCycle();
        flush = 1'b0; ivld[0] = 1'b0;
        void'(sb.pop_front()); void'(sb_part.pop_front()); void'(sb_tag.pop_front());
        midCycle();
        check("flush_kill", ovld[0], 1'b0);
        endCycle();
        ordy = 1'b1;
        midCycle();
        check("flush_no_accept", ovld[0], 1'b0);
        endCycle();

        $display("[TB] LOAD_USE_STALL=0 instance");
        ivld[1] = 1'b1; instr = 32'h0000A283; pc = 32'h300;
        midCycle();
        check("ns_lw_ready", irdy[1], 1'b1);
        endCycle();
        instr = 32'h00028333; pc = 32'h304;
        midCycle();
        check("ns_lw_out", {ovld[1], mem_read[1], rd[1]}, {1'b1, 1'b1, 5'd5});
        check("ns_add_ready", irdy[1], 1'b1);
        endCycle();
        ivld[1] = 1'b0;
        midCycle();
        check("ns_add_out", {ovld[1], mem_read[1], alu_op[1], rd[1]}, {1'b1, 1'b0, 4'd1, 5'd6});
        endCycle();

        $display("[TB] reset during LOAD_USE_STALL=3 stall");
        ivld[2] = 1'b1; instr = 32'h0000A283; pc = 32'h400;
        midCycle();
        check("st3_lw_ready", irdy[2], 1'b1);
        endCycle();
        instr = 32'h00028333; pc = 32'h404;
        midCycle();
        check("st3_lw_out", {ovld[2], rd[2]}, {1'b1, 5'd5});
        check("st3_hazard", irdy[2], 1'b0);
        endCycle();
        rst = 1'b1;
        midCycle();
        check("st3_bubble", ovld[2], 1'b0);
        endCycle();
        rst = 1'b0; ivld[2] = 1'b0;
        midCycle();
        check("st3_rst_outputs",
              {ovld[2], alu_op[2], itype[2], reg_write[2], mem_read[2], mem_write[2],
               rd[2], rs1[2], rs2[2], imm[2], pc_out[2], illegal[2]}, '0);
        check("st3_rst_ready", irdy[2], 1'b1);
        endCycle();
        midCycle();
        check("st3_ready_next", irdy[2], 1'b1);
        endCycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
